fifo_fwft_level: RTL and testbench
==================================

Name: fifo_fwft_level

Overview:
- Next-generation single-clock FIFO: first-word-fall-through (FWFT) read side, fill-level output, almost-full/almost-empty flags.
- Over/underflow-protected: illegal pushes and pops are dropped, never corrupt state.
- Sits between producer/consumer pipelines (store buffers, bus bridges) that need look-ahead data and early back-pressure, not just full/empty.

Parameters:
- DEPTH_WIDTH, 2, log2 of capacity; depth = 2**DEPTH_WIDTH words; must be >= 1.
- DATA_WIDTH, 32, word width in bits; must be >= 1.
- AF_THRESH, 2**DEPTH_WIDTH-1, almost_full_o asserts when level >= AF_THRESH; range 1..depth.
- AE_THRESH, 1, almost_empty_o asserts when level <= AE_THRESH; range 0..depth-1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_data_i  in  DATA_WIDTH  push data.
- wr_en_i  in  1  push request.
- rd_data_o  out  DATA_WIDTH  head-of-queue word, valid while empty_o=0.
- rd_en_i  in  1  pop request; acknowledges current rd_data_o.
- full_o  out  1  level == depth.
- empty_o  out  1  level == 0.
- almost_full_o  out  1  level >= AF_THRESH.
- almost_empty_o  out  1  level <= AE_THRESH.
- level_o  out  DEPTH_WIDTH+1  stored word count, 0..depth.
- overflow_o  out  1  sticky: push attempted while full (see Optional Feature).
- underflow_o  out  1  sticky: pop attempted while empty (see Optional Feature).

Behaviour:
- One clock, clk. rst is synchronous and active-high; it wins over every other input in the same cycle.
- Reset values:
  - pointers = 0, level_o = 0.
  - empty_o = 1, full_o = 0, almost_empty_o = 1.
  - almost_full_o = 0.
  - rd_data_o = 0, overflow_o = 0, underflow_o = 0.
- Storage and pointers:
  - Storage is 2**DEPTH_WIDTH words; full capacity is usable.
  - Read and write pointers are DEPTH_WIDTH+1 bits, wrapping modulo 2**(DEPTH_WIDTH+1).
  - The extra MSB distinguishes full from empty.
- Push and pop acceptance:
  - push = wr_en_i & !full_o, evaluated on pre-edge state.
  - pop = rd_en_i & !empty_o, evaluated on pre-edge state.
  - A rejected request changes nothing except the error flags.
- Push path:
  - An accepted push writes wr_data_i at wptr[DEPTH_WIDTH-1:0] and increments wptr.
- Pop path:
  - An accepted pop increments rptr.
  - On the next cycle, rd_data_o shows the following word, or holds its last value if the FIFO becomes empty.
- FWFT latency:
  - A push into an empty FIFO at edge N gives empty_o=0 and rd_data_o = that word after edge N.
  - There is no extra read cycle.
  - The same holds after a pop leaves exactly one word.
- Level update:
  - level_o is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
  - All flags are derived from registered level/pointers, so they settle in the same cycle as level_o.
- Simultaneous push and pop:
  - With 0 < level < depth, both are accepted and level is unchanged.
  - When full, the pop is accepted and the push rejected; level goes depth-1.
  - When empty, the push is accepted and the pop rejected; level goes to 1.
- Wrap-around: pointer wrap is transparent; data order is preserved across any number of wraps.
- rd_data_o while empty_o=1:
  - Don't-care, except 0 after reset.
  - Must not change on rejected pops.
- Reset mid-operation: contents are discarded logically (memory need not be cleared); the next push is the next head.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow_o sets when wr_en_i & full_o.
  - underflow_o sets when rd_en_i & empty_o.
  - Both flags are sticky until rst.
- Undefined: overflow_o and underflow_o are tied to 0 and no flag registers exist.
- Push/pop behaviour is identical in both builds.

Test Plan (DEPTH_WIDTH=2, DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=1):
- Reset, then push 0xA1 once:
  - Next cycle: empty_o=0, rd_data_o=0xA1, level_o=1, almost_empty_o=1.
- Push 0x01..0x04:
  - full_o=1, level_o=4, almost_full_o=1 from level 3.
  - A 5th push of 0x05 is dropped.
  - Pops return 0x01,0x02,0x03,0x04 in order.
  - overflow_o=1 with FIFO_ERR_FLAGS_EN, 0 without.
- When full, assert wr_en_i and rd_en_i together:
  - 0x01 popped, push rejected, level_o=3, full_o=0.
- When empty, assert wr_en_i=1 (0x55) and rd_en_i=1 together:
  - Push accepted, pop ignored, level_o=1, rd_data_o=0x55.
  - underflow_o=1 with the macro.
- Stream 20 words with simultaneous push/pop at steady level 2:
  - Output sequence equals input sequence across 5 pointer wraps.
  - level_o is constant at 2.
- Fill to 3, assert rst for one cycle with wr_en_i=1:
  - level_o=0, empty_o=1, flags cleared, no write taken.
  - The next push becomes the head.

Source files
------------

// File: rtl/fifo_fwft_level.sv
// fifo_fwft_level: single-clock first-word-fall-through FIFO.
// It has a registered fill level, almost-full and almost-empty flags, and
// drops illegal pushes and pops.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
// When the macro is undefined, both flags are tied low.
//
// Handshake: a push is taken on a rising edge when wr_en_i=1 and full_o=0.
// A pop is taken when rd_en_i=1 and empty_o=0. Both use the state from
// before the edge. rd_data_o is the head word and is valid whenever
// empty_o=0. A pop acknowledges the word being shown at that moment.
module fifo_fwft_level #(
   parameter int DEPTH_WIDTH = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int AF_THRESH   = 2**DEPTH_WIDTH-1,
   parameter int AE_THRESH   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  wr_data_i,
   input  logic                   wr_en_i,
   output logic [DATA_WIDTH-1:0]  rd_data_o,
   input  logic                   rd_en_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   almost_full_o,
   output logic                   almost_empty_o,
   output logic [DEPTH_WIDTH:0]   level_o,
   output logic                   overflow_o,
   output logic                   underflow_o
);

   localparam int DEPTH = 2**DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] DEPTH_L = (DEPTH_WIDTH+1)'(DEPTH);
   localparam logic [DEPTH_WIDTH:0] AF_L    = (DEPTH_WIDTH+1)'(AF_THRESH);
   localparam logic [DEPTH_WIDTH:0] AE_L    = (DEPTH_WIDTH+1)'(AE_THRESH);
   localparam logic [DEPTH_WIDTH:0] ONE_L   = (DEPTH_WIDTH+1)'(1);

   logic [DEPTH_WIDTH:0]  wptr_q, wptr_d;
   logic [DEPTH_WIDTH:0]  rptr_q, rptr_d;
   logic [DEPTH_WIDTH:0]  level_q, level_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   logic full, empty;
   logic push, pop;

   // Status flags come straight from the registered level.
   always_comb begin
      full  = (level_q == DEPTH_L);
      empty = (level_q == '0);
   end

   // Accept requests only when they cannot over- or underflow.
   always_comb begin
      push = wr_en_i & ~full;
      pop  = rd_en_i & ~empty;
   end

   // Next-state logic for storage, pointers, level and the head word.
   always_comb begin
      mem_d     = mem_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      level_d   = level_q;
      rd_data_d = rd_data_q;

      if (push) begin
         mem_d[wptr_q[DEPTH_WIDTH-1:0]] = wr_data_i;
         wptr_d = wptr_q + ONE_L;
      end
      if (pop) begin
         rptr_d = rptr_q + ONE_L;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + ONE_L;
         2'b01:   level_d = level_q - ONE_L;
         default: level_d = level_q;
      endcase

      // The head after the edge is either a word already in storage, or the
      // word being pushed now when everything stored has been consumed.
      // If the FIFO ends up empty, the last shown word is held.
      if (level_d != '0) begin
         if (rptr_d == wptr_q) begin
            rd_data_d = wr_data_i;
         end else begin
            rd_data_d = mem_q[rptr_d[DEPTH_WIDTH-1:0]];
         end
      end
   end

   // Control registers; reset overrides any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage array; it is not cleared, because the pointers define what is live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data_o      = rd_data_q;
   assign level_o        = level_q;
   assign full_o         = full;
   assign empty_o        = empty;
   assign almost_full_o  = (level_q >= AF_L);
   assign almost_empty_o = (level_q <= AE_L);

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error flags: any push into full or pop from empty sets them.
   always_comb begin
      overflow_d  = overflow_q  | (wr_en_i & full);
      underflow_d = underflow_q | (rd_en_i & empty);
   end

   // Error flag registers, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;
`else
   assign overflow_o  = 1'b0;
   assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_fwft_level.sv
// tb_fifo_fwft_level: directed test of fifo_fwft_level.
// It uses DEPTH_WIDTH=2, DATA_WIDTH=8, AF_THRESH=3 and AE_THRESH=1.
// A queue-based reference model is checked against the DUT on every cycle.
// Hand-computed literal checks are made after each directed step.
module tb_fifo_fwft_level;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] level;

  fifo_fwft_level #(
    .DEPTH_WIDTH(2), .DATA_WIDTH(8), .AF_THRESH(3), .AE_THRESH(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_data_i(wr_data), .wr_en_i(wr_en),
    .rd_data_o(rd_data), .rd_en_i(rd_en),
    .full_o(full), .empty_o(empty),
    .almost_full_o(almost_full), .almost_empty_o(almost_empty),
    .level_o(level),
    .overflow_o(overflow), .underflow_o(underflow)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a plain queue of stored words plus last-shown head word
  logic [7:0] exp_q[$];
  logic [7:0] exp_rd = '0;
  logic       exp_ov = 1'b0;
  logic       exp_un = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_rd = '0;
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end else begin
      automatic bit do_push = wr_en && (exp_q.size() < DEPTH);
      automatic bit do_pop  = rd_en && (exp_q.size() > 0);
      if (ERR_EN && wr_en && exp_q.size() == DEPTH) exp_ov = 1'b1;
      if (ERR_EN && rd_en && exp_q.size() == 0)     exp_un = 1'b1;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(wr_data);
      if (exp_q.size() > 0) exp_rd = exp_q[0];
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("level", 32'(level), 32'(exp_q.size()));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(exp_q.size() >= 3));
      check("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= 1));
      check("rd_data", 32'(rd_data), 32'(exp_rd));
      check("overflow", 32'(overflow), 32'(exp_ov));
      check("underflow", 32'(underflow), 32'(exp_un));
    end
  end

  // driver: apply one cycle of requests, return 1 time unit after the edge
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  logic [7:0] stream_exp [22];

  initial begin
    // reset
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);

    // single push falls through with no extra read cycle
    step(1'b1, 8'hA1, 1'b0);
    check("fwft_empty", 32'(empty), 32'd0);
    check("fwft_data", 32'(rd_data), 32'hA1);
    check("fwft_level", 32'(level), 32'd1);
    check("fwft_ae", 32'(almost_empty), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("pop_last_empty", 32'(empty), 32'd1);
    check("pop_last_hold", 32'(rd_data), 32'hA1);

    // fill to full; the fifth push is dropped
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    check("lvl2_af", 32'(almost_full), 32'd0);
    step(1'b1, 8'h03, 1'b0);
    check("lvl3_af", 32'(almost_full), 32'd1);
    step(1'b1, 8'h04, 1'b0);
    check("full_flag", 32'(full), 32'd1);
    check("full_level", 32'(level), 32'd4);
    step(1'b1, 8'h05, 1'b0);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_head", 32'(rd_data), 32'h01);
    check("ovf_flag", 32'(overflow), 32'(ERR_EN));

    // push and pop together while full: only the pop is taken
    step(1'b1, 8'h66, 1'b1);
    check("fullrw_level", 32'(level), 32'd3);
    check("fullrw_full", 32'(full), 32'd0);
    check("fullrw_head", 32'(rd_data), 32'h02);
    step(1'b0, 8'h00, 1'b1);
    check("pop_head3", 32'(rd_data), 32'h03);
    step(1'b0, 8'h00, 1'b1);
    check("pop_head4", 32'(rd_data), 32'h04);
    step(1'b0, 8'h00, 1'b1);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_hold", 32'(rd_data), 32'h04);

    // push and pop together while empty: only the push is taken
    step(1'b1, 8'h55, 1'b1);
    check("emptyrw_level", 32'(level), 32'd1);
    check("emptyrw_data", 32'(rd_data), 32'h55);
    check("unf_flag", 32'(underflow), 32'(ERR_EN));

    // stream 20 words at a steady level of 2, wrapping the pointers 5 times
    step(1'b1, 8'h60, 1'b0);
    stream_exp[0] = 8'h55;
    stream_exp[1] = 8'h60;
    for (int i = 0; i < 20; i++) stream_exp[i+2] = 8'(8'h80 + i);
    for (int i = 0; i < 20; i++) begin
      check("stream_out", 32'(rd_data), 32'(stream_exp[i]));
      step(1'b1, 8'(8'h80 + i), 1'b1);
      check("stream_level", 32'(level), 32'd2);
    end
    for (int i = 20; i < 22; i++) begin
      check("stream_out", 32'(rd_data), 32'(stream_exp[i]));
      step(1'b0, 8'h00, 1'b1);
    end
    check("stream_empty", 32'(empty), 32'd1);

    // reset mid-operation with a push pending: nothing is written
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    check("prerst_level", 32'(level), 32'd3);
    rst = 1'b1;
    step(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_unf", 32'(underflow), 32'd0);
    check("midrst_data", 32'(rd_data), 32'd0);
    step(1'b1, 8'h77, 1'b0);
    check("postrst_head", 32'(rd_data), 32'h77);
    check("postrst_level", 32'(level), 32'd1);
    step(1'b0, 8'h00, 1'b0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
